tmip_gray_loader: RTL and testbench

Parametrised front-end for the template-matching image pipeline. Accepts a serial stream of interleaved colour samples (R, G, B per pixel) and produces three grayscale variants per pixel: max, average and weighted. Emits them as one registered write beat per pixel, addressed for the downstream image SRAM banks. Generalises the fixed 8-bit, three-size loader: data width and maximum image dimension are parameters, and the block adds abort detection and back-to-back frame acceptance.

---
 rtl/tmip_pkg.sv | 19 +
 rtl/tmip_gray_loader_if.sv | 27 ++
 rtl/tmip_gray_alu.sv | 26 ++
 rtl/tmip_gray_loader.sv | 138 +++++++++++++
 tb/tb_tmip_gray_loader.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/tmip_pkg.sv
// Shared types and helpers for the template-matching image pipeline.
package tmip_pkg;

  localparam logic [1:0] SZ_4  = 2'd0;
  localparam logic [1:0] SZ_8  = 2'd1;
  localparam logic [1:0] SZ_16 = 2'd2;
  localparam logic [1:0] SZ_32 = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Image side length for a size code: 4, 8, 16 or 32.
  function automatic int unsigned dim_of(input logic [1:0] code);
    return 32'd4 << code;
  endfunction

endpackage

// File: rtl/tmip_gray_loader_if.sv
// Sample stream in, SRAM write beat and status out, for the gray loader.
interface tmip_gray_loader_if #(
  parameter int DW = 8,
  parameter int AW = 8
);
  logic          in_valid;
  logic [DW-1:0] image;
  logic [1:0]    image_size;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_max;
  logic [DW-1:0] wr_avg;
  logic [DW-1:0] wr_wgt;
  logic          done;
  logic          abort;
  logic          busy;

  modport master (
    output in_valid, image, image_size,
    input  wr_en, wr_addr, wr_max, wr_avg, wr_wgt, done, abort, busy
  );

  modport slave (
    input  in_valid, image, image_size,
    output wr_en, wr_addr, wr_max, wr_avg, wr_wgt, done, abort, busy
  );
endinterface

// File: rtl/tmip_gray_alu.sv
// Combinational RGB to grayscale: max, exact floor average, and quarter/half/quarter weighting.
module tmip_gray_alu #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] r,
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] gmax,
  output logic [DW-1:0] gavg,
  output logic [DW-1:0] gwgt
);
  localparam int SW = DW + 2;

  logic [SW-1:0] sum;
  logic [DW-1:0] max_rg;

  always_comb begin
    sum    = SW'(r) + SW'(g) + SW'(b);
    max_rg = (r > g) ? r : g;
    gmax   = (max_rg > b) ? max_rg : b;
    // sum <= 3*(2^DW-1), so the quotient always fits DW bits
    gavg   = DW'(sum / SW'(3));
    // each term is truncated first; the total peaks at 2^DW - 3
    gwgt   = (r >> 2) + (g >> 1) + (b >> 2);
  end
endmodule

// File: rtl/tmip_gray_loader.sv
// Serial RGB sample loader: groups R,G,B beats into pixels and emits one registered
// grayscale write beat per pixel, with frame done/abort detection and back-to-back frames.
//
// state   | meaning
// IDLE    | waiting for the first beat (R of pixel 0) of a frame
// RUN     | collecting channels; frame_full marks the last pixel already written
module tmip_gray_loader
  import tmip_pkg::*;
#(
  parameter int DW       = 8,
  parameter int MAX_CODE = 2,
  parameter int AW       = 2 * (MAX_CODE + 2)
) (
  input logic              clk,
  input logic              rst_n,
  tmip_gray_loader_if.slave bus
);
  localparam logic [1:0] MAX_CODE_L = 2'(MAX_CODE);

  state_t        state;
  logic          frame_full;
  logic [1:0]    ch_cnt;
  logic [1:0]    code_q;
  logic [AW-1:0] pix_cnt;
  logic [DW-1:0] r_q;
  logic [DW-1:0] g_q;

  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_max_q;
  logic [DW-1:0] wr_avg_q;
  logic [DW-1:0] wr_wgt_q;
  logic          done_q;
  logic          abort_q;
  logic          busy_q;

  logic [1:0]    code_in;
  logic [AW-1:0] last_pix;
  logic          start;
  logic [DW-1:0] alu_max;
  logic [DW-1:0] alu_avg;
  logic [DW-1:0] alu_wgt;

  always_comb begin
    code_in  = (bus.image_size > MAX_CODE_L) ? MAX_CODE_L : bus.image_size;
    last_pix = AW'(dim_of(code_q) * dim_of(code_q) - 32'd1);
    // a new frame can begin from IDLE or in the cycle right after the last B beat
    start    = bus.in_valid && ((state == ST_IDLE) || frame_full);
  end

  tmip_gray_alu #(.DW(DW)) u_alu (
    .r    (r_q),
    .g    (g_q),
    .b    (bus.image),
    .gmax (alu_max),
    .gavg (alu_avg),
    .gwgt (alu_wgt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      frame_full <= 1'b0;
      ch_cnt     <= '0;
      code_q     <= '0;
      pix_cnt    <= '0;
      r_q        <= '0;
      g_q        <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_max_q   <= '0;
      wr_avg_q   <= '0;
      wr_wgt_q   <= '0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      if (start) begin
        state      <= ST_RUN;
        frame_full <= 1'b0;
        code_q     <= code_in;
        r_q        <= bus.image;
        ch_cnt     <= 2'd1;
        pix_cnt    <= '0;
        busy_q     <= 1'b1;
      end else if ((state == ST_IDLE) || frame_full) begin
        state      <= ST_IDLE;
        frame_full <= 1'b0;
        ch_cnt     <= '0;
        pix_cnt    <= '0;
        busy_q     <= 1'b0;
      end else if (!bus.in_valid) begin
        // early end: drop the partial pixel; busy clears on the following cycle
        state   <= ST_IDLE;
        abort_q <= 1'b1;
        ch_cnt  <= '0;
        pix_cnt <= '0;
      end else begin
        case (ch_cnt)
          2'd0: begin
            r_q    <= bus.image;
            ch_cnt <= 2'd1;
          end
          2'd1: begin
            g_q    <= bus.image;
            ch_cnt <= 2'd2;
          end
          default: begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= pix_cnt;
            wr_max_q  <= alu_max;
            wr_avg_q  <= alu_avg;
            wr_wgt_q  <= alu_wgt;
            done_q    <= (pix_cnt == last_pix);
            ch_cnt    <= 2'd0;
            pix_cnt   <= pix_cnt + AW'(1);
            if (pix_cnt == last_pix) begin
              frame_full <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_max  = wr_max_q;
  assign bus.wr_avg  = wr_avg_q;
  assign bus.wr_wgt  = wr_wgt_q;
  assign bus.done    = done_q;
  assign bus.abort   = abort_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_tmip_gray_loader.sv
// Directed bench for tmip_gray_loader: single pixel, saturation, size clamp, abort,
// back-to-back frames and mid-frame reset.
module tb_tmip_gray_loader;
  import tmip_pkg::*;

  localparam int DW       = 8;
  localparam int MAX_CODE = 2;
  localparam int AW       = 2 * (MAX_CODE + 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_wr     = 0;
  int   n_done   = 0;

  tmip_gray_loader_if #(.DW(DW), .AW(AW)) bus ();

  tmip_gray_loader #(.DW(DW), .MAX_CODE(MAX_CODE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one beat, then land on the next falling edge where the response is visible.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [1:0] sz);
    bus.in_valid   = v;
    bus.image      = d;
    bus.image_size = sz;
    @(negedge clk);
    if (bus.wr_en) n_wr++;
    if (bus.done)  n_done++;
  endtask

  function automatic logic [DW-1:0] samp(input int mode, input int t);
    if (mode == 0) return '1;
    if (mode == 2) return DW'(t * 53 + 7);
    return DW'(t * 37 + 11);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"},   32'(bus.wr_en),   32'd0);
    chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
    chk({tag, "_wr_max"},  32'(bus.wr_max),  32'd0);
    chk({tag, "_wr_avg"},  32'(bus.wr_avg),  32'd0);
    chk({tag, "_wr_wgt"},  32'(bus.wr_wgt),  32'd0);
    chk({tag, "_done"},    32'(bus.done),    32'd0);
    chk({tag, "_abort"},   32'(bus.abort),   32'd0);
    chk({tag, "_busy"},    32'(bus.busy),    32'd0);
  endtask

  // Beats t0..nbeats-1 of a frame with side length dim; image_size only valid on beat 0.
  task automatic frame(input logic [1:0] sz, input int dim, input int nbeats,
                       input int mode, input int t0);
    logic [DW-1:0] s;
    int r = 0;
    int g = 0;
    int b = 0;
    int mx, npix;
    npix = dim * dim;
    for (int t = t0; t < nbeats; t++) begin
      s = samp(mode, t);
      step(1'b1, s, (t == 0) ? sz : 2'(t));
      case (t % 3)
        0:       r = int'(s);
        1:       g = int'(s);
        default: b = int'(s);
      endcase
      if (t < nbeats - 1) chk("busy", 32'(bus.busy), 32'd1);
      chk("abort", 32'(bus.abort), 32'd0);
      if (t % 3 == 2) begin
        mx = (r > g) ? r : g;
        mx = (mx > b) ? mx : b;
        chk("wr_en",   32'(bus.wr_en),   32'd1);
        chk("wr_addr", 32'(bus.wr_addr), 32'(t / 3));
        chk("wr_max",  32'(bus.wr_max),  32'(mx));
        chk("wr_avg",  32'(bus.wr_avg),  32'((r + g + b) / 3));
        chk("wr_wgt",  32'(bus.wr_wgt),  32'(r / 4 + g / 2 + b / 4));
        chk("done",    32'(bus.done),    32'(t / 3 == npix - 1));
      end else begin
        chk("wr_en_idle", 32'(bus.wr_en), 32'd0);
        chk("done_idle",  32'(bus.done),  32'd0);
      end
    end
  endtask

  task automatic idle_after_frame(input string tag);
    step(1'b0, '0, 2'd0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({tag, "_done"},  32'(bus.done),  32'd0);
    chk({tag, "_abort"}, 32'(bus.abort), 32'd0);
    chk({tag, "_busy"},  32'(bus.busy),  32'd0);
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.image      = '0;
    bus.image_size = 2'd0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(1'b0, '0, 2'd0);

    // single pixel (10,20,30) by hand, then the rest of the 4x4 frame
    n_wr = 0; n_done = 0;
    step(1'b1, 8'd10, SZ_4);
    chk("t1_busy",  32'(bus.busy),  32'd1);
    chk("t1_wr_en0", 32'(bus.wr_en), 32'd0);
    step(1'b1, 8'd20, 2'd3);
    chk("t1_wr_en1", 32'(bus.wr_en), 32'd0);
    step(1'b1, 8'd30, 2'd3);
    chk("t1_wr_en",  32'(bus.wr_en),   32'd1);
    chk("t1_addr",   32'(bus.wr_addr), 32'd0);
    chk("t1_max",    32'(bus.wr_max),  32'd30);
    chk("t1_avg",    32'(bus.wr_avg),  32'd20);
    chk("t1_wgt",    32'(bus.wr_wgt),  32'd19);
    chk("t1_done",   32'(bus.done),    32'd0);
    frame(SZ_4, 4, 48, 2, 3);
    idle_after_frame("t1_end");
    chk("t1_nwr",   32'(n_wr),   32'd16);
    chk("t1_ndone", 32'(n_done), 32'd1);

    // saturated samples
    n_wr = 0; n_done = 0;
    frame(SZ_4, 4, 48, 0, 0);
    chk("t2_last_addr", 32'(bus.wr_addr), 32'd15);
    chk("t2_last_max",  32'(bus.wr_max),  32'd255);
    chk("t2_last_avg",  32'(bus.wr_avg),  32'd255);
    chk("t2_last_wgt",  32'(bus.wr_wgt),  32'd253);
    chk("t2_last_done", 32'(bus.done),    32'd1);
    idle_after_frame("t2_end");
    chk("t2_nwr",   32'(n_wr),   32'd16);
    chk("t2_ndone", 32'(n_done), 32'd1);

    // 16x16 frame
    n_wr = 0; n_done = 0;
    frame(SZ_16, 16, 768, 1, 0);
    idle_after_frame("t3_end");
    chk("t3_nwr",   32'(n_wr),   32'd256);
    chk("t3_ndone", 32'(n_done), 32'd1);

    // 32x32 request clamps to 16x16
    n_wr = 0; n_done = 0;
    frame(SZ_32, 16, 768, 2, 0);
    idle_after_frame("t4_end");
    chk("t4_nwr",   32'(n_wr),   32'd256);
    chk("t4_ndone", 32'(n_done), 32'd1);

    // abort after 7 beats, then a clean frame restarts at address 0
    n_wr = 0; n_done = 0;
    frame(SZ_4, 4, 7, 1, 0);
    step(1'b0, 8'hAA, 2'd0);
    chk("t5_abort",  32'(bus.abort), 32'd1);
    chk("t5_wr_en",  32'(bus.wr_en), 32'd0);
    chk("t5_done",   32'(bus.done),  32'd0);
    step(1'b0, 8'hAA, 2'd0);
    chk("t5_abort_end", 32'(bus.abort), 32'd0);
    chk("t5_busy_end",  32'(bus.busy),  32'd0);
    chk("t5_nwr",   32'(n_wr),   32'd2);
    chk("t5_ndone", 32'(n_done), 32'd0);
    n_wr = 0; n_done = 0;
    frame(SZ_4, 4, 48, 1, 0);
    idle_after_frame("t5_next");
    chk("t5_next_nwr", 32'(n_wr), 32'd16);

    // back-to-back 4x4 then 8x8 with no gap
    n_wr = 0; n_done = 0;
    frame(SZ_4, 4, 48, 1, 0);
    chk("t6_first_nwr",   32'(n_wr),   32'd16);
    chk("t6_first_ndone", 32'(n_done), 32'd1);
    frame(SZ_8, 8, 192, 2, 0);
    idle_after_frame("t6_end");
    chk("t6_nwr",   32'(n_wr),   32'd80);
    chk("t6_ndone", 32'(n_done), 32'd2);

    // reset on beat 20 of an 8x8 frame
    frame(SZ_8, 8, 20, 1, 0);
    chk("t7_pre_addr", 32'(bus.wr_addr), 32'd5);
    bus.in_valid = 1'b1;
    bus.image    = 8'd99;
    #1 rst_n = 1'b0;
    #1 chk_all_zero("t7_rst");
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_wr = 0; n_done = 0;
    idle_after_frame("t7_release");
    frame(SZ_4, 4, 48, 1, 0);
    idle_after_frame("t7_end");
    chk("t7_nwr",   32'(n_wr),   32'd16);
    chk("t7_ndone", 32'(n_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
